// File: rtl/des_key_sched_dec.sv
// DES key schedule delivering round subkeys K16..K1 for decryption, one per transfer.
// Optional DES_KS_BIDIR_EN adds a decrypt input; decrypt=0 selects encryption order K1..K16.
module des_key_sched_dec (
   input  logic        clk,
   input  logic        n_rst,
   input  logic [63:0] key_in,
   input  logic        key_valid,
   output logic        key_ready,
   output logic [47:0] subkey,
   output logic        subkey_valid,
   input  logic        subkey_req,
   output logic [3:0]  round,
   output logic        done
`ifdef DES_KS_BIDIR_EN
   ,
   input  logic        decrypt
`endif
);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   // Table entries are 1-based DES bit numbers, bit 1 being the MSB.
   localparam int PC1_TBL [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TBL [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) begin
         r[55-i] = k[6'(64 - PC1_TBL[i])];
      end
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) begin
         r[47-i] = cd[6'(56 - PC2_TBL[i])];
      end
      return r;
   endfunction

   // Shift amount for DES round k (1..16) is 1 for rounds 1, 2, 9, 16 and 2 otherwise.
   function automatic logic shift_is_two(input logic [4:0] k);
      return !(k == 5'd1 || k == 5'd2 || k == 5'd9 || k == 5'd16);
   endfunction

   function automatic logic [27:0] rol28(input logic [27:0] x, input logic two);
      return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] ror28(input logic [27:0] x, input logic two);
      return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   state_t      state_q, state_d;
   logic [27:0] c_q, c_d;
   logic [27:0] d_q, d_d;
   logic [3:0]  round_q, round_d;
   logic        enc_mode;
   logic        last_xfer;
   logic        xfer;
   logic [55:0] cd_load;

`ifdef DES_KS_BIDIR_EN
   logic enc_q, enc_d;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         enc_q <= 1'b0;
      end else begin
         enc_q <= enc_d;
      end
   end

   always_comb begin
      enc_d = enc_q;
      if (state_q == IDLE && key_valid) begin
         enc_d = !decrypt;
      end
   end

   assign enc_mode = enc_q;
`else
   assign enc_mode = 1'b0;
`endif

   assign xfer      = (state_q == ACTIVE) && subkey_req;
   assign last_xfer = enc_mode ? (round_q == 4'd15) : (round_q == 4'd0);
   assign cd_load   = pc1(key_in);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (key_valid) state_d = ACTIVE;
         ACTIVE:  if (xfer && last_xfer) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         c_q     <= '0;
         d_q     <= '0;
         round_q <= '0;
      end else begin
         c_q     <= c_d;
         d_q     <= d_d;
         round_q <= round_d;
      end
   end

   // Decrypt starts from C0/D0, which equal C16/D16 since the shifts total 28.
   always_comb begin
      c_d     = c_q;
      d_d     = d_q;
      round_d = round_q;
      if (state_q == IDLE && key_valid) begin
`ifdef DES_KS_BIDIR_EN
         if (!decrypt) begin
            c_d     = rol28(cd_load[55:28], shift_is_two(5'd1));
            d_d     = rol28(cd_load[27:0], shift_is_two(5'd1));
            round_d = 4'd0;
         end else begin
            c_d     = cd_load[55:28];
            d_d     = cd_load[27:0];
            round_d = 4'd15;
         end
`else
         c_d     = cd_load[55:28];
         d_d     = cd_load[27:0];
         round_d = 4'd15;
`endif
      end else if (xfer && !last_xfer) begin
         if (enc_mode) begin
            c_d     = rol28(c_q, shift_is_two({1'b0, round_q} + 5'd2));
            d_d     = rol28(d_q, shift_is_two({1'b0, round_q} + 5'd2));
            round_d = round_q + 4'd1;
         end else begin
            c_d     = ror28(c_q, shift_is_two({1'b0, round_q} + 5'd1));
            d_d     = ror28(d_q, shift_is_two({1'b0, round_q} + 5'd1));
            round_d = round_q - 4'd1;
         end
      end else if (state_q == DONE) begin
         round_d = 4'd0;
      end
   end

   always_comb begin
      key_ready    = (state_q == IDLE);
      subkey_valid = (state_q == ACTIVE);
      done         = (state_q == DONE);
      subkey       = '0;
      round        = '0;
      if (state_q == ACTIVE) begin
         subkey = pc2({c_q, d_q});
         round  = round_q;
      end
   end

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Randomized bench for des_key_sched_dec against a forward-schedule DES reference model.
module tb_des_key_sched_dec;

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam logic [63:0] KNOWN_KEY = 64'h1334_5779_9BBC_DFF1;

   logic        clk;
   logic        n_rst;
   logic [63:0] key_in;
   logic        key_valid;
   logic        key_ready;
   logic [47:0] subkey;
   logic        subkey_valid;
   logic        subkey_req;
   logic [3:0]  round;
   logic        done;
`ifdef DES_KS_BIDIR_EN
   logic        decrypt;
`endif

   int n_chk = 0;
   int n_err = 0;
   bit mode_dec = 1'b1;

   des_key_sched_dec dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .key_in       (key_in),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .subkey       (subkey),
      .subkey_valid (subkey_valid),
      .subkey_req   (subkey_req),
      .round        (round),
      .done         (done)
`ifdef DES_KS_BIDIR_EN
      ,
      .decrypt      (decrypt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_err);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: DES forward schedule, K_n from C0/D0 rotated left by the cumulative shift.
   function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int n);
      logic [55:0] cd0;
      logic [55:0] cc;
      logic [55:0] dd;
      logic [55:0] cd;
      logic [47:0] r;
      int tot;
      tot = 0;
      for (int i = 0; i < 56; i++) cd0[55-i] = key[6'(64 - PC1[i])];
      for (int k = 1; k <= n; k++) tot += (k == 1 || k == 2 || k == 9 || k == 16) ? 1 : 2;
      cc = {cd0[55:28], cd0[55:28]} << tot;
      dd = {cd0[27:0], cd0[27:0]} << tot;
      cd = {cc[55:28], dd[55:28]};
      for (int j = 0; j < 48; j++) r[47-j] = cd[6'(56 - PC2[j])];
      return r;
   endfunction

   task automatic accept(input logic [63:0] key);
      int t;
      t = 0;
      while (!key_ready && t < 50) begin
         step();
         t++;
      end
      chk("accept_ready", 64'(key_ready), 64'd1);
      key_valid  = 1'b1;
      key_in     = key;
      subkey_req = 1'b0;
`ifdef DES_KS_BIDIR_EN
      decrypt    = mode_dec;
`endif
      step();
      key_valid  = 1'b0;
      key_in     = {$urandom, $urandom};
   endtask

   // Consumes the remaining subkeys from position pos0, checking order, values, and the DONE cycle.
   task automatic drain(input logic [63:0] key, input bit rnd, input bit chain,
                        input logic [63:0] nkey, input int pos0);
      int pos;
      int cyc;
      int n;
      bit req;
      pos = pos0;
      cyc = 0;
      while (pos < 16 && cyc < 400) begin
         n = mode_dec ? 16 - pos : pos + 1;
         chk("sk_valid", 64'(subkey_valid), 64'd1);
         chk("sk_value", 64'(subkey), 64'(ref_subkey(key, n)));
         chk("sk_round", 64'(round), 64'(n - 1));
         req = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         subkey_req = req;
         if (pos == 7) begin
            key_valid = 1'b1;
            key_in    = 64'hFFFF_FFFF_FFFF_FFFF;
         end else if (pos == 15 && chain) begin
            key_valid = 1'b1;
            key_in    = nkey;
         end else begin
            key_valid = 1'($urandom_range(0, 1));
            key_in    = {$urandom, $urandom};
         end
         step();
         if (req) pos++;
         cyc++;
      end
      if (pos < 16) chk("drain_timeout", 64'(pos), 64'd16);
      if (!chain) key_valid = 1'b0;
      chk("done_pulse", 64'(done), 64'd1);
      chk("done_valid", 64'(subkey_valid), 64'd0);
      chk("done_ready", 64'(key_ready), 64'd0);
      chk("done_subkey", 64'(subkey), 64'd0);
      chk("done_round", 64'(round), 64'd0);
      subkey_req = 1'($urandom_range(0, 1));
      step();
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_ready", 64'(key_ready), 64'd1);
      chk("idle_valid", 64'(subkey_valid), 64'd0);
      if (chain) begin
         step();
         key_valid = 1'b0;
      end
   endtask

   initial begin
      int seen;
      logic [63:0] k1;
      logic [63:0] k2;
      bit ch;
      n_rst      = 1'b0;
      key_in     = '0;
      key_valid  = 1'b0;
      subkey_req = 1'b0;
`ifdef DES_KS_BIDIR_EN
      decrypt    = 1'b1;
`endif
      step();
      step();
      chk("rst_ready", 64'(key_ready), 64'd1);
      chk("rst_valid", 64'(subkey_valid), 64'd0);
      chk("rst_subkey", 64'(subkey), 64'd0);
      chk("rst_round", 64'(round), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      n_rst = 1'b1;
      step();

      // Known-answer run with stalls on K15.
      mode_dec = 1'b1;
      accept(KNOWN_KEY);
      chk("kat_k16", 64'(subkey), 64'h0000_CB3D_8B0E_17F5);
      chk("kat_r15", 64'(round), 64'd15);
      subkey_req = 1'b1;
      step();
      for (int c = 0; c < 3; c++) begin
         chk("hold_k15", 64'(subkey), 64'h0000_BF91_8D3D_3F0A);
         chk("hold_r14", 64'(round), 64'd14);
         subkey_req = (c == 2);
         step();
      end
      drain(KNOWN_KEY, 1'b0, 1'b0, 64'd0, 2);

      // Back-to-back known-answer run with subkey_req held high.
      accept(KNOWN_KEY);
      subkey_req = 1'b1;
      for (int c = 1; c < 16; c++) begin
         if (c == 2) chk("b2b_k15", 64'(subkey), 64'h0000_BF91_8D3D_3F0A);
         step();
      end
      chk("b2b_k1", 64'(subkey), 64'h0000_1B02_EFFC_7072);
      chk("b2b_r0", 64'(round), 64'd0);
      step();
      chk("b2b_done", 64'(done), 64'd1);
      subkey_req = 1'b0;
      step();

      // Reset mid-schedule must abort without a done pulse.
      accept(KNOWN_KEY);
      subkey_req = 1'b1;
      for (int c = 0; c < 10; c++) step();
      chk("abort_r5", 64'(round), 64'd5);
      n_rst = 1'b0;
      #1;
      chk("abort_valid", 64'(subkey_valid), 64'd0);
      chk("abort_ready", 64'(key_ready), 64'd1);
      chk("abort_subkey", 64'(subkey), 64'd0);
      subkey_req = 1'b0;
      step();
      n_rst = 1'b1;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (done) seen++;
         step();
      end
      chk("abort_nodone", 64'(seen), 64'd0);

      // key_valid held through DONE: accepted only on the first IDLE edge.
      k1 = {$urandom, $urandom};
      k2 = {$urandom, $urandom};
      accept(k1);
      drain(k1, 1'b1, 1'b1, k2, 0);
      drain(k2, 1'b1, 1'b0, 64'd0, 0);

`ifdef DES_KS_BIDIR_EN
      mode_dec = 1'b0;
      accept(KNOWN_KEY);
      chk("enc_k1", 64'(subkey), 64'h0000_1B02_EFFC_7072);
      chk("enc_r0", 64'(round), 64'd0);
      subkey_req = 1'b1;
      for (int c = 1; c < 16; c++) step();
      chk("enc_k16", 64'(subkey), 64'h0000_CB3D_8B0E_17F5);
      chk("enc_r15", 64'(round), 64'd15);
      step();
      chk("enc_done", 64'(done), 64'd1);
      subkey_req = 1'b0;
      step();
`endif

      for (int it = 0; it < 10; it++) begin
`ifdef DES_KS_BIDIR_EN
         mode_dec = 1'($urandom_range(0, 1));
`else
         mode_dec = 1'b1;
`endif
         k1 = {$urandom, $urandom};
         k2 = {$urandom, $urandom};
         ch = 1'($urandom_range(0, 1));
         accept(k1);
         drain(k1, 1'b1, ch, k2, 0);
         if (ch) drain(k2, 1'b1, 1'b0, 64'd0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/des_key_sched_dec.md
DES_KEY_SCHED_DEC -- requirements
Module: des_key_sched_dec

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port key_in, input, 64 bits: DES key; DES bit 1 = key_in[63]; parity bits (8,16,...,64) ignored.
REQ-004 SHALL have port key_valid, input, 1 bit: key_in is valid this cycle.
REQ-005 SHALL have port key_ready, output, 1 bit: block is idle and accepts a key.
REQ-006 SHALL have port subkey, output, 48 bits: current round subkey; PC-2 bit 1 = subkey[47].
REQ-007 SHALL have port subkey_valid, output, 1 bit: subkey holds a valid round key.
REQ-008 SHALL have port subkey_req, input, 1 bit: consumer takes subkey this cycle.
REQ-009 SHALL have port round, output, 4 bits: index of presented subkey, value = DES round number minus 1.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse after the final subkey is taken.

Function
REQ-011 SHALL implement FSM states IDLE, ACTIVE, DONE; key_ready = 1 only in IDLE.
REQ-012 SHALL accept a key on a rising edge where key_valid=1 and key_ready=1: load C,D = PC-1(key_in) and enter ACTIVE.
REQ-013 SHALL ignore key_valid while key_ready=0; key_in is not sampled.
REQ-014 SHALL present K16 = PC-2(C,D) with round=15 and subkey_valid=1 in the first cycle after acceptance (latency 1).
REQ-015 SHALL count a transfer on each edge where subkey_valid=1 and subkey_req=1; subkey and round hold unchanged while subkey_req=0.
REQ-016 SHALL, on a transfer while presenting round r (r>0), rotate C and D right by shift(r+1) and decrement round; shift(1..16) = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-017 SHALL produce one subkey per cycle when subkey_req is held high: K16..K1 in 16 consecutive cycles.
REQ-018 SHALL, on the transfer of round=0 (K1), enter DONE for exactly one cycle with done=1 and subkey_valid=0, then return to IDLE.
REQ-019 SHALL drive subkey=0 and round=0 whenever subkey_valid=0.
REQ-020 SHALL never accept a new key in the DONE cycle; key_valid held through DONE is accepted on the first IDLE edge.
REQ-021 SHALL wrap round only by returning to IDLE; round never decrements below 0.

Reset
REQ-022 SHALL, on n_rst=0, immediately enter IDLE with C=D=0, round=0, subkey=0, subkey_valid=0, done=0, key_ready=1.
REQ-023 SHALL abort any in-progress schedule on reset; no done pulse is produced for an aborted key.

Configuration
REQ-024 SHALL support macro DES_KS_BIDIR_EN; when defined, add input port decrypt (1 bit), sampled at key acceptance only.
REQ-025 SHALL, with DES_KS_BIDIR_EN and decrypt=0, first rotate C,D left by shift(1) and present K1 with round=0, then on each transfer rotate left by shift(round+2) and increment round; the transfer at round=15 enters DONE.
REQ-026 SHALL, with DES_KS_BIDIR_EN and decrypt=1, or without the macro, behave exactly per REQ-014..REQ-018; without the macro, port decrypt does not exist.

Verification
REQ-027 SHALL check: after reset, key 0x133457799BBCDFF1 accepted, subkey_req=1 -> cycle 1 subkey=0xCB3D8B0E17F5 round=15; cycle 2 subkey=0xBF918D3D3F0A round=14; cycle 16 subkey=0x1B02EFFC7072 round=0; cycle 17 done=1.
REQ-028 SHALL check: same key, subkey_req toggled 1,0,0,1 -> subkey holds 0xBF918D3D3F0A for three cycles, round=14 throughout.
REQ-029 SHALL check: key_valid=1 with key 0xFFFFFFFFFFFFFFFF at round=8 -> ignored; remaining subkeys match the original key.
REQ-030 SHALL check: n_rst=0 asserted at round=5 -> next sample subkey_valid=0, key_ready=1, subkey=0, done never pulses.
REQ-031 SHALL check: key_valid held high from the K1 transfer onward -> DONE cycle has key_ready=0; key accepted on the following edge; K16 presented one cycle later.
REQ-032 SHALL check (DES_KS_BIDIR_EN, decrypt=0): key 0x133457799BBCDFF1 -> first subkey=0x1B02EFFC7072 round=0; sixteenth subkey=0xCB3D8B0E17F5 round=15.
